// File: rtl/div_ctrl.sv
// EX-stage controller for the multi-cycle divider: decodes DIV/DIVU/REM/REMU, resolves trivial cases locally.
// Latency 1 for fast/cache results, divider latency + 1 otherwise; stalls the pipeline via hold_o while busy.
module div_ctrl #(
  parameter int unsigned FAST_PATH_EN = 1,
  parameter int unsigned CACHE_EN     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        hold_o,
  output logic        div_start_o,
  output logic [3:0]  div_op_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  input  logic [31:0] div_result_i,
  input  logic        div_ready_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      r_state;
  logic        r_first;
  logic [3:0]  r_op;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic [4:0]  r_rd;
  logic [2:0]  r_f3;
  logic        r_wb_vld;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  logic        r_c_vld;
  logic [2:0]  r_c_f3;
  logic [31:0] r_c_rs1;
  logic [31:0] r_c_rs2;
  logic [31:0] r_c_res;

  logic        w_launch;
  logic        w_div0;
  logic        w_ovf;
  logic        w_fast;
  logic        w_hit;
  logic        w_miss;
  logic        w_rdy_ok;
  logic        w_run;
  logic [31:0] w_fast_data;

  assign w_launch = (r_state == S_IDLE) & req_valid_i & ~flush_i;
  assign w_div0   = (rs2_data_i == 32'h0000_0000);
  // funct3[0]==0 selects the signed ops (DIV, REM)
  assign w_ovf    = ~funct3_i[0] & (rs1_data_i == 32'h8000_0000) & (rs2_data_i == 32'hFFFF_FFFF);
  assign w_fast   = (FAST_PATH_EN != 0) & (w_div0 | w_ovf);
  assign w_hit    = (CACHE_EN != 0) & r_c_vld & (funct3_i == r_c_f3)
                  & (rs1_data_i == r_c_rs1) & (rs2_data_i == r_c_rs2);
  assign w_miss   = w_launch & ~w_fast & ~w_hit;

  // funct3[1] selects remainder; div-by-zero wins over overflow
  assign w_fast_data = w_div0 ? (funct3_i[1] ? rs1_data_i : 32'hFFFF_FFFF)
                              : (funct3_i[1] ? 32'h0000_0000 : 32'h8000_0000);

  // a ready seen in the first busy cycle is a leftover from the previous op
  assign w_rdy_ok = div_ready_i & ~r_first;
  assign w_run    = (r_state == S_BUSY) & ~w_rdy_ok & ~flush_i;

  assign hold_o      = w_miss | w_run;
  assign div_start_o = w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_first    <= 1'b0;
      r_op       <= 4'b0000;
      r_dividend <= 32'h0;
      r_divisor  <= 32'h0;
      r_rd       <= 5'd0;
      r_f3       <= 3'd0;
      r_wb_vld   <= 1'b0;
      r_wb_addr  <= 5'd0;
      r_wb_data  <= 32'h0;
      r_c_vld    <= 1'b0;
      r_c_f3     <= 3'd0;
      r_c_rs1    <= 32'h0;
      r_c_rs2    <= 32'h0;
      r_c_res    <= 32'h0;
    end else begin
      r_wb_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            if (w_fast) begin
              r_wb_vld  <= 1'b1;
              r_wb_addr <= rd_addr_i;
              r_wb_data <= w_fast_data;
            end else if (w_hit) begin
              r_wb_vld  <= 1'b1;
              r_wb_addr <= rd_addr_i;
              r_wb_data <= r_c_res;
            end else begin
              r_state    <= S_BUSY;
              r_first    <= 1'b1;
              r_op       <= 4'b1000 >> funct3_i[1:0];
              r_dividend <= rs1_data_i;
              r_divisor  <= rs2_data_i;
              r_rd       <= rd_addr_i;
              r_f3       <= funct3_i;
            end
          end
        end
        S_BUSY: begin
          r_first <= 1'b0;
          if (flush_i) begin
            r_state <= S_IDLE;
          end else if (w_rdy_ok) begin
            r_state   <= S_IDLE;
            r_wb_vld  <= 1'b1;
            r_wb_addr <= r_rd;
            r_wb_data <= div_result_i;
            if (CACHE_EN != 0) begin
              r_c_vld <= 1'b1;
              r_c_f3  <= r_f3;
              r_c_rs1 <= r_dividend;
              r_c_rs2 <= r_divisor;
              r_c_res <= div_result_i;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign div_op_o       = r_op;
  assign div_dividend_o = r_dividend;
  assign div_divisor_o  = r_divisor;
  assign wb_valid_o     = r_wb_vld;
  assign wb_addr_o      = r_wb_addr;
  assign wb_data_o      = r_wb_data;

endmodule
